// File: rtl/sap1_pkg.sv
// Shared opcodes, T-state encodings and control-word layout for the SAP-1 controller.
// Optional build macro SAP1_VARIABLE_CYCLE_EN is consumed by sap1_ctrl, not here.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic pc_en;
    logic pc_incr;
    logic mar_load;
    logic ir_load;
    logic ir_enable;
    logic mem_en;
    logic a_load;
    logic a_enable;
    logic b_load;
    logic alu_enable;
    logic alu_sub;
    logic o_load;
  } ctrl_word_t;

  // Raw decode for one T-state; alu_sub is driven separately as a mode pin.
  function automatic ctrl_word_t decode(tstate_e t, logic [3:0] op);
    ctrl_word_t cw;
    logic       is_mem_op;
    logic       is_alu_op;
    cw        = '0;
    is_alu_op = (op == OP_ADD) || (op == OP_SUB);
    is_mem_op = (op == OP_LDA) || is_alu_op;
    unique case (t)
      T1: begin
        cw.pc_en    = 1'b1;
        cw.mar_load = 1'b1;
      end
      T2: cw.pc_incr = 1'b1;
      T3: begin
        cw.mem_en  = 1'b1;
        cw.ir_load = 1'b1;
      end
      T4: begin
        if (is_mem_op) begin
          cw.ir_enable = 1'b1;
          cw.mar_load  = 1'b1;
        end else if (op == OP_OUT) begin
          cw.a_enable = 1'b1;
          cw.o_load   = 1'b1;
        end
      end
      T5: begin
        if (op == OP_LDA) begin
          cw.mem_en = 1'b1;
          cw.a_load = 1'b1;
        end else if (is_alu_op) begin
          cw.mem_en = 1'b1;
          cw.b_load = 1'b1;
        end
      end
      T6: begin
        if (is_alu_op) begin
          cw.alu_enable = 1'b1;
          cw.a_load     = 1'b1;
        end
      end
      default: cw = '0;
    endcase
    return cw;
  endfunction

endpackage

// File: rtl/sap1_step_gen.sv
// Run/single-step qualifier: turns the front-panel step level into a one-cycle
// pulse and produces the per-cycle advance enable.
module sap1_step_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic step,
  input  logic halted,
  output logic advance
);

  logic step_q;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step;
    end
  end

  // run dominates, so a step edge coinciding with run rising still yields one advance.
  assign advance = ~halted & (run | (step & ~step_q));

endmodule

// File: rtl/sap1_ctrl.sv
// SAP-1 T-state sequencer and instruction decoder; state changes on the falling clock edge.
// Define SAP1_VARIABLE_CYCLE_EN to end LDA/OUT/NOP instructions early.
module sap1_ctrl
  import sap1_pkg::*;
#(
  parameter int unsigned NUM_T = 6,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             fp_clear_n,
  input  logic [3:0]       opcode,
  input  logic             run,
  input  logic             step,
  output logic             pc_en,
  output logic             pc_incr,
  output logic             mar_load,
  output logic             ir_load,
  output logic             ir_enable,
  output logic             mem_en,
  output logic             a_load,
  output logic             a_enable,
  output logic             b_load,
  output logic             alu_enable,
  output logic             alu_sub,
  output logic             o_load,
  output logic [5:0]       tstate,
  output logic             halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  if (NUM_T != 6) begin : g_bad_num_t
    $error("sap1_ctrl: NUM_T must be 6");
  end

  tstate_e          t_q, t_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance;
  logic             is_defined;
  logic             last_t;
  ctrl_word_t       cw_raw;
  ctrl_word_t       cw_out;

  sap1_step_gen u_step_gen (
    .clk     (clk),
    .rst_n   (fp_clear_n),
    .run     (run),
    .step    (step),
    .halted  (halted_q),
    .advance (advance)
  );

  always_comb begin
    is_defined = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB) ||
                 (opcode == OP_OUT) || (opcode == OP_HLT);
`ifdef SAP1_VARIABLE_CYCLE_EN
    last_t = (t_q == T6) ||
             ((t_q == T5) && (opcode == OP_LDA)) ||
             ((t_q == T4) && ((opcode == OP_OUT) || !is_defined));
`else
    last_t = (t_q == T6);
`endif
  end

  always_comb begin
    t_d       = t_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (advance) begin
      if ((t_q == T4) && (opcode == OP_HLT)) begin
        halted_d = 1'b1;
      end else if (last_t) begin
        t_d   = T1;
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        unique case (t_q)
          T1:      t_d = T2;
          T2:      t_d = T3;
          T3:      t_d = T4;
          T4:      t_d = T5;
          T5:      t_d = T6;
          default: t_d = T1;
        endcase
      end
      if ((t_q == T4) && !is_defined) begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(negedge clk or negedge fp_clear_n) begin
    if (!fp_clear_n) begin
      t_q       <= T1;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      t_q       <= t_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // Loads only fire on an advancing cycle so a stalled step cycle cannot repeat them.
  always_comb begin
    cw_raw = decode(t_q, opcode);
    cw_out = (advance && fp_clear_n) ? cw_raw : '0;
    cw_out.alu_sub = fp_clear_n && (opcode == OP_SUB);
  end

  assign {pc_en, pc_incr, mar_load, ir_load, ir_enable, mem_en,
          a_load, a_enable, b_load, alu_enable, alu_sub, o_load} = cw_out;

  assign tstate      = t_q;
  assign halted      = halted_q;
  assign illegal_op  = illegal_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_sap1_ctrl.sv
// Self-checking bench for sap1_ctrl: per-cycle comparison against a behavioural
// model, plus directed scenarios with hand-computed expectations.
module tb_sap1_ctrl;

  localparam int CNT_W = 8;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             fp_clear_n = 1'b1;
  logic [3:0]       opcode = 4'h0;
  logic             run = 1'b0;
  logic             step = 1'b0;
  logic             pc_en, pc_incr, mar_load, ir_load, ir_enable, mem_en;
  logic             a_load, a_enable, b_load, alu_enable, alu_sub, o_load;
  logic [5:0]       tstate;
  logic             halted, illegal_op;
  logic [CNT_W-1:0] instr_count;
  logic [11:0]      dut_ctrl;

  int checks = 0;
  int failures = 0;

  sap1_ctrl #(.NUM_T(6), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .fp_clear_n  (fp_clear_n),
    .opcode      (opcode),
    .run         (run),
    .step        (step),
    .pc_en       (pc_en),
    .pc_incr     (pc_incr),
    .mar_load    (mar_load),
    .ir_load     (ir_load),
    .ir_enable   (ir_enable),
    .mem_en      (mem_en),
    .a_load      (a_load),
    .a_enable    (a_enable),
    .b_load      (b_load),
    .alu_enable  (alu_enable),
    .alu_sub     (alu_sub),
    .o_load      (o_load),
    .tstate      (tstate),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .instr_count (instr_count)
  );

  assign dut_ctrl = {pc_en, pc_incr, mar_load, ir_load, ir_enable, mem_en,
                     a_load, a_enable, b_load, alu_enable, alu_sub, o_load};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_t = 1;        // current T-state number 1..6
  bit m_halted = 0;
  bit m_illegal = 0;
  int m_cnt = 0;
  bit m_stepq = 0;

  function automatic bit defined_op(logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF};
  endfunction

  // Number of T-states an instruction occupies.
  function automatic int instr_len(logic [3:0] op);
`ifdef SAP1_VARIABLE_CYCLE_EN
    if (op == 4'h0) return 5;
    if (op == 4'h1 || op == 4'h2) return 6;
    if (op == 4'hF) return 6;
    return 4;
`else
    return 6;
`endif
  endfunction

  function automatic bit m_adv();
    return fp_clear_n && !m_halted && (run || (step && !m_stepq));
  endfunction

  // Expected control word in port order from the T-state table.
  function automatic logic [11:0] exp_ctrl(int t, logic [3:0] op, bit adv, bit rst_ok);
    logic [11:0] w;
    bit alu_op, mem_op;
    w = '0;
    alu_op = (op == 4'h1) || (op == 4'h2);
    mem_op = alu_op || (op == 4'h0);
    case (t)
      1: begin w[11] = 1; w[9] = 1; end
      2: w[10] = 1;
      3: begin w[6] = 1; w[8] = 1; end
      4: if (mem_op) begin w[7] = 1; w[9] = 1; end
         else if (op == 4'hE) begin w[4] = 1; w[0] = 1; end
      5: if (op == 4'h0) begin w[6] = 1; w[5] = 1; end
         else if (alu_op) begin w[6] = 1; w[3] = 1; end
      6: if (alu_op) begin w[2] = 1; w[5] = 1; end
      default: w = '0;
    endcase
    if (!adv) w = '0;
    w[1] = rst_ok && (op == 4'h2);
    return w;
  endfunction

  always @(negedge clk or negedge fp_clear_n) begin
    if (!fp_clear_n) begin
      m_t <= 1; m_halted <= 0; m_illegal <= 0; m_cnt <= 0; m_stepq <= 0;
    end else begin
      if (m_adv()) begin
        if (m_t == 4 && opcode == 4'hF) begin
          m_halted <= 1;
        end else if (m_t == 6 || m_t == instr_len(opcode)) begin
          m_t <= 1;
          m_cnt <= (m_cnt + 1) % CNT_MOD;
        end else begin
          m_t <= m_t + 1;
        end
        if (m_t == 4 && !defined_op(opcode)) m_illegal <= 1;
      end
      m_stepq <= step;
    end
  end

  // Compare process: outputs are sampled mid-high-phase, well away from the falling edge.
  always @(posedge clk) begin
    #2;
    chk("tstate", {26'd0, tstate}, 32'(1 << (m_t - 1)));
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("illegal_op", {31'd0, illegal_op}, {31'd0, m_illegal});
    chk("instr_count", {24'd0, instr_count}, 32'(m_cnt));
    chk("ctrl", {20'd0, dut_ctrl}, {20'd0, exp_ctrl(m_t, opcode, m_adv(), fp_clear_n)});
  end

  // ---------------- directed + random stimulus ----------------
  task automatic do_reset();
    @(posedge clk);
    fp_clear_n = 1'b0;
    @(posedge clk);
    fp_clear_n = 1'b1;
  endtask

  int hits;

  initial begin
    run = 1'b1;
    opcode = 4'h2;
    #1 fp_clear_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("rst_tstate", {26'd0, tstate}, 32'h01);
    chk("rst_ctrl", {20'd0, dut_ctrl}, 32'h0);
    chk("rst_count", {24'd0, instr_count}, 32'h0);

    // LDA free-run for 12 clocks.
    @(posedge clk);
    fp_clear_n = 1'b1;
    opcode = 4'h0;
    run = 1'b1;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(posedge clk);
      #3;
      if (mem_en && a_load) begin
        hits++;
        chk("lda_a_load_t5", {26'd0, tstate}, 32'h10);
      end
    end
    @(posedge clk);
    run = 1'b0;
    #3;
    chk("lda_a_load_hits", 32'(hits), 32'd2);
    chk("lda_count", {24'd0, instr_count}, 32'd2);
`ifdef SAP1_VARIABLE_CYCLE_EN
    chk("lda_tstate", {26'd0, tstate}, 32'h04);
`else
    chk("lda_tstate", {26'd0, tstate}, 32'h01);
`endif

    // Single-step: stalled cycles are silent, one edge gives one T1 cycle.
    do_reset();
    run = 1'b0; step = 1'b0; opcode = 4'h0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(posedge clk);
      #3;
      chk("stall_tstate", {26'd0, tstate}, 32'h01);
      chk("stall_ctrl", {20'd0, dut_ctrl}, 32'h0);
    end
    @(posedge clk);
    step = 1'b1;
    #3;
    chk("step_t1_ctrl", {20'd0, dut_ctrl}, 32'h0A00);
    @(posedge clk);
    #3;
    chk("step_held_tstate", {26'd0, tstate}, 32'h02);
    chk("step_held_ctrl", {20'd0, dut_ctrl}, 32'h0);
    @(posedge clk);
    step = 1'b0;

    // HLT latches at T4 and ignores run/step until reset.
    do_reset();
    opcode = 4'hF; run = 1'b1;
    for (int i = 0; i < 4; i++) @(posedge clk);
    #3;
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    chk("hlt_tstate", {26'd0, tstate}, 32'h08);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      step = ~step;
      run = i[0];
      #3;
      chk("hlt_hold_tstate", {26'd0, tstate}, 32'h08);
      chk("hlt_hold_ctrl", {20'd0, dut_ctrl}, 32'h0);
    end
    do_reset();
    step = 1'b0; run = 1'b0;
    #3;
    chk("hlt_clr_halted", {31'd0, halted}, 32'd0);
    chk("hlt_clr_tstate", {26'd0, tstate}, 32'h01);

    // SUB: alu_enable and a_load together in T6 only, alu_sub throughout.
    do_reset();
    opcode = 4'h2; run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(posedge clk);
      #3;
      chk("sub_alu_sub", {31'd0, alu_sub}, 32'd1);
      chk("sub_alu_en", {31'd0, alu_enable & a_load}, (i == 5) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    opcode = 4'h1;
    #3;
    chk("add_alu_sub", {31'd0, alu_sub}, 32'd0);

    // Undefined opcode, then a reset in the middle of the following T-state.
    do_reset();
    opcode = 4'h5; run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(posedge clk);
      #3;
      if (i == 3) chk("ill_t4_ctrl", {20'd0, dut_ctrl}, 32'h0);
    end
    @(posedge clk);
    #3;
    chk("ill_flag", {31'd0, illegal_op}, 32'd1);
    #1 fp_clear_n = 1'b0;
    #1;
    chk("ill_rst_ctrl", {20'd0, dut_ctrl}, 32'h0);
    chk("ill_rst_tstate", {26'd0, tstate}, 32'h01);
    chk("ill_rst_flag", {31'd0, illegal_op}, 32'd0);
    @(posedge clk);
    fp_clear_n = 1'b1;

    // OUT retirement rate.
    do_reset();
    opcode = 4'hE; run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(posedge clk);
      #3;
`ifdef SAP1_VARIABLE_CYCLE_EN
      if (i == 4) chk("out_wrap_t1", {26'd0, tstate}, 32'h01);
`else
      if (i == 4) chk("out_t5", {26'd0, tstate}, 32'h10);
`endif
    end
    @(posedge clk);
    run = 1'b0;
    #3;
`ifdef SAP1_VARIABLE_CYCLE_EN
    chk("out_count", {24'd0, instr_count}, 32'd3);
`else
    chk("out_count", {24'd0, instr_count}, 32'd2);
`endif

    // Randomised run: opcode only changes at instruction boundaries.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      fp_clear_n = ($urandom_range(0, 99) != 0);
      run = ($urandom_range(0, 2) == 0);
      step = $urandom_range(0, 1);
      if (m_t == 1) begin
        case ($urandom_range(0, 19))
          0, 1, 2, 3:     opcode = 4'h0;
          4, 5, 6, 7:     opcode = 4'h1;
          8, 9, 10, 11:   opcode = 4'h2;
          12, 13, 14, 15: opcode = 4'hE;
          16:             opcode = 4'hF;
          default:        opcode = 4'($urandom_range(3, 13));
        endcase
      end
    end
    @(posedge clk);
    fp_clear_n = 1'b1;
    @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
